// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [1:0] {
        StIdle,  // no result held
        StMul,   // shift-add multiply running
        StHold   // result valid, waiting for consumer
    } alu_state_e;

endpackage

// File: rtl/sequential_alu_if.sv
// Handshake bundle of the sequential ALU.
//   master: requester/consumer side (drives operation request and OUT_READY)
//   slave : ALU side (drives IN_READY, result, flags, BUSY)
interface sequential_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_SEL;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] ALU_RESULT;
    logic [3:0]       FLAGS;
    logic             BUSY;

    modport master (
        output IN_VALID, A, B, ALU_SEL, OUT_READY,
        input  IN_READY, OUT_VALID, ALU_RESULT, FLAGS, BUSY
    );

    modport slave (
        input  IN_VALID, A, B, ALU_SEL, OUT_READY,
        output IN_READY, OUT_VALID, ALU_RESULT, FLAGS, BUSY
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier, one partial-product step per cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : load a_i/b_i and begin WIDTH steps
//   a_i, b_i      : operands
//   done_o        : high during the final step cycle; product_o is valid while done_o is high
//   product_o     : 2*WIDTH-bit product (value after the current step)
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            mcand_d = {{WIDTH{1'b0}}, a_i};
            mplr_d  = b_i;
            acc_d   = '0;
            cnt_d   = CntW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d   = acc_q + (mplr_q[0] ? mcand_q : '0);
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q - CntW'(1);
        end
    end

    // The last step's sum is exposed combinationally so the caller can latch it on that edge.
    assign done_o    = (cnt_q == CntW'(1));
    assign product_o = acc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sequential_alu.sv
// Sequential ALU with valid/ready handshake on both sides and a multi-cycle multiplier.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : slave side of sequential_alu_if (request A/B/ALU_SEL, result ALU_RESULT/FLAGS,
//                handshakes IN_VALID/IN_READY and OUT_VALID/OUT_READY, BUSY while multiplying)
module sequential_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    sequential_alu_if.slave    bus
);

    localparam int unsigned     Msb   = WIDTH - 1;
    localparam logic [WIDTH-1:0] ShLim = WIDTH'(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             in_ready;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;
    logic [3:0]       mul_flags;

    always_comb begin
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StHold:  in_ready = bus.OUT_READY;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept    = bus.IN_VALID && in_ready;
    assign mul_start = accept && (bus.ALU_SEL == OP_MUL);

    // Single-cycle datapath, evaluated on the live inputs at the accept edge.
    always_comb begin
        add_w   = {1'b0, bus.A} + {1'b0, bus.B};
        sub_w   = {1'b0, bus.A} - {1'b0, bus.B};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.ALU_SEL)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (bus.A[Msb] == bus.B[Msb]) && (add_w[Msb] != bus.A[Msb]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];  // borrow out equals A < B unsigned
                alu_v   = (bus.A[Msb] != bus.B[Msb]) && (sub_w[Msb] != bus.A[Msb]);
            end
            OP_AND:  alu_res = bus.A & bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_NOT:  alu_res = ~bus.A;
            OP_XOR:  alu_res = bus.A ^ bus.B;
            OP_SHL:  alu_res = (bus.B >= ShLim) ? '0 : (bus.A << bus.B);
            OP_SHR:  alu_res = (bus.B >= ShLim) ? '0 : (bus.A >> bus.B);
            OP_SRA:  alu_res = (bus.B >= ShLim) ? {WIDTH{bus.A[Msb]}}
                                                : WIDTH'($signed(bus.A) >>> bus.B);
            default: alu_res = '0;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_N] = alu_res[Msb];
        alu_flags[FLAG_V] = alu_v;
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_Z] = (alu_res == '0);
    end

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_N] = mul_product[Msb];
        mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .start_i   (mul_start),
        .a_i       (bus.A),
        .b_i       (bus.B),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            StIdle, StHold: begin
                if (accept) begin
                    if (bus.ALU_SEL == OP_MUL) begin
                        state_d = StMul;
                    end else begin
                        state_d  = StHold;
                        result_d = alu_res;
                        flags_d  = alu_flags;
                    end
                end else if ((state_q == StHold) && bus.OUT_READY) begin
                    state_d = StIdle;
                end
            end
            StMul: begin
                if (mul_done) begin
                    state_d  = StHold;
                    result_d = mul_product[WIDTH-1:0];
                    flags_d  = mul_flags;
                end
            end
            default: state_d = StIdle;
        endcase
        out_valid_d = (state_d == StHold);
        busy_d      = (state_d == StMul);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.IN_READY   = in_ready;
    assign bus.OUT_VALID  = out_valid_q;
    assign bus.BUSY       = busy_q;
    assign bus.ALU_RESULT = result_q;
    assign bus.FLAGS      = flags_q;

endmodule

// File: doc/sequential_alu.md
SEQUENTIAL_ALU -- requirements
Module: sequential_alu

Interface
REQ-001 The block SHALL be parametrised by WIDTH, default 8, meaning the operand and result width in bits (legal range 4..64).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port RST_N, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port IN_VALID, input, 1, operation request valid.
REQ-005 The block SHALL have port IN_READY, output, 1, block can accept an operation this cycle.
REQ-006 The block SHALL have port A, input, WIDTH, operand A.
REQ-007 The block SHALL have port B, input, WIDTH, operand B (shift amount for shift ops).
REQ-008 The block SHALL have port ALU_SEL, input, 4, opcode.
REQ-009 The block SHALL have port OUT_VALID, output, 1, result and flags valid.
REQ-010 The block SHALL have port OUT_READY, input, 1, consumer accepts result.
REQ-011 The block SHALL have port ALU_RESULT, output, WIDTH, registered result.
REQ-012 The block SHALL have port FLAGS, output, 4, registered {N,V,C,Z}, bit3..bit0.
REQ-013 The block SHALL have port BUSY, output, 1, multi-cycle multiply in progress.

Function
REQ-014 The block SHALL transfer an operation on any rising edge with IN_VALID=1 and IN_READY=1; the result SHALL transfer on any edge with OUT_VALID=1 and OUT_READY=1.
REQ-015 The opcodes SHALL be: 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 NOT A, 0101 XOR, 0110 SHL, 0111 SHR logical, 1000 SRA, 1001 MUL; every other code SHALL yield result 0.
REQ-016 All arithmetic SHALL be modulo 2^WIDTH; MUL SHALL return the low WIDTH bits of the unsigned product.
REQ-017 Shift amount SHALL be the full unsigned value of B; amount >= WIDTH SHALL give 0 for SHL/SHR and WIDTH copies of A[WIDTH-1] for SRA.
REQ-018 Flags: Z = (result==0); N = result MSB; C = carry-out for ADD, borrow (A<B unsigned) for SUB, nonzero upper product half for MUL, else 0; V = signed overflow for ADD/SUB, else 0.
REQ-019 The state machine SHALL have states IDLE (output empty), MUL (multiply running), HOLD (result valid, waiting).
REQ-020 IDLE + accept of non-MUL op -> HOLD; result visible with OUT_VALID=1 one cycle after the accept edge.
REQ-021 IDLE + accept of MUL -> MUL for exactly WIDTH cycles (one shift-add step per cycle), then HOLD; OUT_VALID rises WIDTH+1 cycles after the accept edge.
REQ-022 HOLD + OUT_READY=0 -> HOLD with ALU_RESULT and FLAGS stable.
REQ-023 HOLD + OUT_READY=1 -> IDLE if no new accept; same edge accept of non-MUL op -> HOLD with new result (back-to-back, one result per cycle); same edge accept of MUL -> MUL.
REQ-024 IN_READY SHALL be 1 in IDLE, equal OUT_READY in HOLD, 0 in MUL; IN_READY SHALL not depend on IN_VALID.
REQ-025 BUSY SHALL be 1 exactly while in MUL.
REQ-026 Operands and opcode SHALL be captured on the accept edge; later changes to A, B, ALU_SEL SHALL not affect an operation in flight.
REQ-027 Outside HOLD, ALU_RESULT and FLAGS SHALL hold their last values (0 after reset).

Reset
REQ-028 RST_N=0 SHALL immediately force state IDLE, OUT_VALID=0, BUSY=0, ALU_RESULT=0, FLAGS=0, multiply counter and accumulators to 0; IN_READY=1 as IDLE.
REQ-029 Reset during MUL or HOLD SHALL discard the in-flight operation with no result produced after release.
REQ-030 The first accept SHALL be possible on the first rising edge after RST_N deasserts.

Structure
REQ-031 A shared package alu_pkg SHALL hold the opcode constants, flag bit index constants (FLAG_N=3, FLAG_V=2, FLAG_C=1, FLAG_Z=0) and the state encoding.
REQ-032 The shift-add multiplier SHALL be one sub-module, alu_mul_seq (start, operands in; done, 2*WIDTH product out), instantiated once.

Verification (WIDTH=8)
REQ-033 ADD A=0xFF, B=0x01, OUT_READY=1 -> next cycle ALU_RESULT=0x00, FLAGS Z=1, C=1, V=0, N=0.
REQ-034 SUB A=0x80, B=0x01 -> ALU_RESULT=0x7F, V=1, C=0, N=0; SUB A=0x01, B=0x02 -> 0xFF, C=1, N=1.
REQ-035 MUL A=0x10, B=0x11 -> BUSY=1 for 8 cycles, IN_READY=0, OUT_VALID after 9 cycles, ALU_RESULT=0x10, C=1.
REQ-036 Back-to-back ADD,XOR,SHL(B=9) with OUT_READY=1 -> three results on consecutive cycles; SHL result 0x00, Z=1; OUT_READY=0 for 3 cycles -> result and flags held, IN_READY=0.
REQ-037 SRA A=0x90, B=0x02 -> 0xE4, N=1; opcode 1111 -> result 0x00, Z=1.
REQ-038 RST_N pulsed low at cycle 4 of a MUL -> OUT_VALID=0, BUSY=0, ALU_RESULT=0 immediately; no result emerges afterwards; ADD accepted on first edge after release.
